// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle for the iterative multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes with sign fix-up
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  mdu
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   m_q, m_d, q_q, q_d, r_q, r_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_sh, div_df;
    logic [2*WIDTH-1:0] prod_fix;

    // cnt_q==0 is a setup cycle (zero-divisor check, magnitudes); cnt 1..WIDTH are the iterations
    always_comb begin
        a_neg    = ~op_q[0] & a_q[WIDTH-1];
        b_neg    = ~op_q[0] & b_q[WIDTH-1];
        mul_sum  = {1'b0, r_q} + ({1'b0, m_q} & {(WIDTH+1){q_q[0]}});
        div_sh   = {r_q, q_q[WIDTH-1]};
        div_df   = div_sh - {1'b0, m_q};
        prod_fix = (a_neg ^ b_neg) ? -{r_q, q_q} : {r_q, q_q};
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        q_d      = q_q;
        r_d      = r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (mdu.start) begin
                op_d    = mdu.op;
                a_d     = mdu.a;
                b_d     = mdu.b;
                dz_d    = 1'b0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: if (cnt_q == '0) begin
                dz_d    = op_q[1] && (b_q == '0);
                state_d = (op_q[1] && (b_q == '0)) ? DONE : CALC;
                m_d     = b_neg ? -b_q : b_q;
                q_d     = a_neg ? -a_q : a_q;
                r_d     = '0;
                cnt_d   = CW'(1);
            end else begin
                r_d     = op_q[1] ? (div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0]) : mul_sum[WIDTH:1];
                q_d     = op_q[1] ? {q_q[WIDTH-2:0], ~div_df[WIDTH]} : {mul_sum[0], q_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH)) ? FIX : CALC;
            end
            FIX: begin
                hi_d    = op_q[1] ? (a_neg ? -r_q : r_q) : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = op_q[1] ? ((a_neg ^ b_neg) ? -q_q : q_q) : prod_fix[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            q_q     <= q_d;
            r_q     <= r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign mdu.busy     = state_q != IDLE;
    assign mdu.done     = state_q == DONE;
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
    assign mdu.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a result scoreboard checked by an independent monitor
module tb_mult_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    mult_div_unit_if #(.WIDTH(32)) m ();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .mdu(m));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int lat);
        @(negedge clk);
        m.start = 1'b1;
        m.op    = o;
        m.a     = x;
        m.b     = y;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        if (push) exp_q.push_back('{eh, el, edz, cyc + lat});
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("timeout_pending", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset) prev_done <= 1'b0;
        else begin
            if (prev_done) chk("busy_after_done", 64'(m.busy), 0);
            if (m.done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("hi", 64'(m.hi), 64'(e.hi));
                    chk("lo", 64'(m.lo), 64'(e.lo));
                    chk("div_zero", 64'(m.div_zero), 64'(e.dz));
                    chk("done_cycle", 64'(cyc), 64'(e.t));
                    chk("busy_at_done", 64'(m.busy), 1);
                end
            end
            prev_done <= m.done;
        end
    end

    initial begin
        m.start = 1'b0;
        m.op    = 2'd0;
        m.a     = '0;
        m.b     = '0;
        #1;
        chk("rst_busy", 64'(m.busy), 0);
        chk("rst_done", 64'(m.done), 0);
        chk("rst_hi", 64'(m.hi), 0);
        chk("rst_lo", 64'(m.lo), 0);
        chk("rst_dz", 64'(m.div_zero), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(2'b00, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34); wait_empty();
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h1, 0, 34); wait_empty();
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34); wait_empty();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0, 34); wait_empty();
        issue(2'b11, 32'd100, 32'd0, 1, 32'h0, 32'h80000000, 1, 1); wait_empty();
        issue(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 34);
        repeat (4) @(negedge clk);
        m.start = 1'b1;
        m.op    = 2'b00;
        m.a     = 32'd9;
        m.b     = 32'd9;
        @(negedge clk);
        m.start = 1'b0;
        for (int i = 0; i < 100 && !m.done; i++) @(negedge clk);
        m.start = 1'b1;
        @(negedge clk);
        m.start = 1'b0;
        wait_empty();
        issue(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 1, 32'h0, 32'h1E, 0, 34); wait_empty();
        issue(2'b00, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0, 0, 34); wait_empty();
        issue(2'b10, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0, 34); wait_empty();
        issue(2'b11, 32'hFFFFFFFF, 32'd10, 1, 32'd5, 32'h19999999, 0, 34); wait_empty();
        issue(2'b00, 32'd12, 32'd12, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(m.busy), 0);
        chk("abort_done", 64'(m.done), 0);
        chk("abort_hi", 64'(m.hi), 0);
        chk("abort_lo", 64'(m.lo), 0);
        chk("abort_dz", 64'(m.div_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'b01, 32'd3, 32'd5, 1, 32'd0, 32'd15, 0, 34); wait_empty();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
